axi_slave_mem: RTL and testbench

Synthesizable AXI4 slave memory that terminates one slave port of the AXI VIP interface array, consuming the master-driven AW/W/AR channels and producing B/R responses. It serves as the default downstream target for VIP masters in block- and system-level benches. It provides word-addressed storage with byte strobes, FIXED/INCR bursts, error responses, and independent read and write engines with one outstanding transaction each.

---
 rtl/axi_vip_pkg.sv | 34 +++
 rtl/axi_addr_gen.sv | 40 ++++
 rtl/axi_slave_mem.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_vip_pkg.sv
// Shared AXI4 definitions for the VIP slave memory: burst/resp encodings,
// engine state types and the response-severity merge used for bresp.
package axi_vip_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'd0,
        RespExokay = 2'd1,
        RespSlverr = 2'd2,
        RespDecerr = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_t;

    typedef enum logic {
        RIdle,
        RData
    } rd_state_t;

    // Encodings are ordered by severity, so the worse response is the larger code.
    function automatic resp_e resp_max(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational beat decode: word index, range check, burst/size legality and the
// address of the following beat (FIXED holds, INCR steps from the size-aligned base).
module axi_addr_gen
    import axi_vip_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [2:0]                   size_i,
    input  logic [1:0]                   burst_i,
    output logic [ADDR_W-1:0]            next_addr_o,
    output logic [$clog2(MEM_DEPTH)-1:0] index_o,
    output logic                         in_range_o,
    output logic                         err_o
);

    localparam int unsigned LANE_W = $clog2(DATA_W / 8);

    logic              borrow;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] aligned;

    always_comb begin
        // The borrow flags addresses below the window without a constant compare.
        {borrow, offset} = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        word        = offset >> LANE_W;
        in_range_o  = !borrow && (word < ADDR_W'(MEM_DEPTH));
        index_o     = word[$clog2(MEM_DEPTH)-1:0];
        err_o       = !(burst_i inside {BurstFixed, BurstIncr}) || (size_i > 3'(LANE_W));
        step        = ADDR_W'(1) << size_i;
        aligned     = addr_i & ~(step - ADDR_W'(1));
        next_addr_o = (burst_i == BurstFixed) ? addr_i : aligned + step;
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent single-outstanding write and read engines over a
// word array with byte strobes, FIXED/INCR bursts and per-beat error responses.
module axi_slave_mem
    import axi_vip_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;

    function automatic resp_e beat_resp(input logic in_range, input logic err);
        if (!in_range) return RespDecerr;
        if (err) return RespSlverr;
        return RespOkay;
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    wr_state_t         wstate_q, wstate_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    resp_e             bresp_q, bresp_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [7:0]        wlen_q, wlen_d;
    logic [8:0]        wcnt_q, wcnt_d;

    rd_state_t         rstate_q, rstate_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    resp_e             rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;

    logic [ADDR_W-1:0] wr_next, rd_next, rd_gen_addr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_in_range, wr_err, rd_in_range, rd_err, wr_en;
    logic [2:0]        rd_gen_size;
    logic [1:0]        rd_gen_burst;
    resp_e             wr_beat_resp, rd_beat_resp;
    logic [DATA_W-1:0] rd_beat_data;
    logic              wr_in_len, wr_last_beat;

    axi_addr_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_DEPTH(MEM_DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) u_wr_gen (
        .addr_i     (waddr_q),
        .size_i     (wsize_q),
        .burst_i    (wburst_q),
        .next_addr_o(wr_next),
        .index_o    (wr_idx),
        .in_range_o (wr_in_range),
        .err_o      (wr_err)
    );

    // While idle the read decoder looks at AR so beat 0 is ready the cycle after the handshake.
    assign rd_gen_addr  = (rstate_q == RIdle) ? araddr : raddr_q;
    assign rd_gen_size  = (rstate_q == RIdle) ? arsize : rsize_q;
    assign rd_gen_burst = (rstate_q == RIdle) ? arburst : rburst_q;

    axi_addr_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_DEPTH(MEM_DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) u_rd_gen (
        .addr_i     (rd_gen_addr),
        .size_i     (rd_gen_size),
        .burst_i    (rd_gen_burst),
        .next_addr_o(rd_next),
        .index_o    (rd_idx),
        .in_range_o (rd_in_range),
        .err_o      (rd_err)
    );

    assign wr_beat_resp = beat_resp(wr_in_range, wr_err);
    assign rd_beat_resp = beat_resp(rd_in_range, rd_err);
    assign rd_beat_data = (rd_beat_resp == RespOkay) ? mem[rd_idx] : '0;
    assign wr_in_len    = wcnt_q <= {1'b0, wlen_q};
    assign wr_last_beat = wcnt_q == {1'b0, wlen_q};

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wr_en     = 1'b0;
        case (wstate_q)
            WIdle: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = WData;
                    bid_d     = awid;
                    bresp_d   = RespOkay;
                    waddr_d   = awaddr;
                    wsize_d   = awsize;
                    wburst_d  = awburst;
                    wlen_d    = awlen;
                    wcnt_d    = '0;
                end
            end
            WData: begin
                if (wvalid && wready_q) begin
                    if (wr_in_len) begin
                        bresp_d = resp_max(bresp_d, wr_beat_resp);
                        wr_en   = (wr_beat_resp == RespOkay);
                    end
                    // Covers early wlast, missing wlast at awlen and wlast after awlen.
                    if (wlast != wr_last_beat) bresp_d = resp_max(bresp_d, RespSlverr);
                    waddr_d = wr_next;
                    if (wcnt_q != '1) wcnt_d = wcnt_q + 9'd1;
                    if (wlast) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        wstate_d = WResp;
                    end
                end
            end
            WResp: begin
                if (bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        case (rstate_q)
            RIdle: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = RData;
                    rid_d     = arid;
                    rlen_d    = arlen;
                    rsize_d   = arsize;
                    rburst_d  = arburst;
                    rcnt_d    = '0;
                    rlast_d   = (arlen == 8'd0);
                    rdata_d   = rd_beat_data;
                    rresp_d   = rd_beat_resp;
                    raddr_d   = rd_next;
                end
            end
            RData: begin
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = RIdle;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = (rcnt_q + 8'd1 == rlen_q);
                        rdata_d = rd_beat_data;
                        rresp_d = rd_beat_resp;
                        raddr_d = rd_next;
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q  <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RespOkay;
            waddr_q   <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            rstate_q  <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Storage is deliberately not reset; beats already committed survive a reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed scenarios plus random bursts checked against a
// word-array memory model that derives beat addresses and responses arithmetically.
module tb_axi_slave_mem;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wd  [DEPTH];
    logic [3:0]  ws  [DEPTH];

    always #5 aclk = ~aclk;

    axi_slave_mem #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .ID_W     (4),
        .MEM_DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .awid   (awid),
        .awaddr (awaddr),
        .awlen  (awlen),
        .awsize (awsize),
        .awburst(awburst),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wlast  (wlast),
        .wvalid (wvalid),
        .wready (wready),
        .bid    (bid),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .arid   (arid),
        .araddr (araddr),
        .arlen  (arlen),
        .arsize (arsize),
        .arburst(arburst),
        .arvalid(arvalid),
        .arready(arready),
        .rid    (rid),
        .rdata  (rdata),
        .rresp  (rresp),
        .rlast  (rlast),
        .rvalid (rvalid),
        .rready (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: beat n of a burst; anything but FIXED steps from the size-aligned start.
    function automatic logic [31:0] m_addr(input logic [31:0] start, input logic [2:0] size,
                                           input logic [1:0] burst, input int n);
        logic [31:0] sz;
        sz = 32'd1 << size;
        if (burst == 2'd0 || n == 0) return start;
        return (start / sz) * sz + 32'(n) * sz;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [1:0] burst);
        if (a < BASE || (a - BASE) / 4 >= 32'(DEPTH)) return 2'd3;
        if (burst > 2'd1 || size > 3'd2) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int lp);
        int          t;
        logic [1:0]  exp, r;
        logic [31:0] a;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check("awready_wait", awready, 1'b1);
        @(negedge aclk);
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1'b1);
        for (int i = 0; i <= lp; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge aclk);
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == lp);
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            check("wready_wait", wready, 1'b1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_wlast", bvalid, 1'b1);
        exp = (lp == len) ? 2'd0 : 2'd2;
        for (int i = 0; i <= lp && i <= len; i++) begin
            a = m_addr(addr, size, burst, i);
            r = m_resp(a, size, burst);
            if (r > exp) exp = r;
            if (r == 2'd0) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mdl[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1'b1);
        end
        bready = 1'b1;
        check("bid", bid, id);
        check("bresp", bresp, exp);
        @(negedge aclk);
        bready = 1'b0;
        check("awready_after_b", awready, 1'b1);
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    // mode 0: rready held high, 1: random stalls, 2: alternate stall/accept per beat
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int          t, stalls;
        logic [31:0] a, d;
        logic [1:0]  r;
        logic [34:0] held;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check("arready_wait", arready, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            stalls = (mode == 0) ? 0 : (mode == 2) ? 1 : int'($urandom_range(0, 2));
            check("rvalid", rvalid, 1'b1);
            held = {rdata, rresp, rlast};
            for (int s = 0; s < stalls; s++) begin
                rready = 1'b0;
                @(negedge aclk);
                check("r_stable", {rdata, rresp, rlast}, held);
            end
            a = m_addr(addr, size, burst, i);
            r = m_resp(a, size, burst);
            d = (r == 2'd0) ? mdl[m_idx(a)] : 32'd0;
            rready = 1'b1;
            check("rdata", rdata, d);
            check("rresp", rresp, r);
            check("rlast", rlast, (i == len));
            check("rid", rid, id);
            @(negedge aclk);
            rready = 1'b0;
        end
        check("arready_after_r", arready, 1'b1);
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_ids", {bid, rid}, 8'h00);
        check("rst_resps", {bresp, rresp}, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("awready_after_rst", awready, 1'b1);
        check("arready_after_rst", arready, 1'b1);

        // Give the whole array known contents.
        for (int i = 0; i < DEPTH; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h1, BASE, DEPTH - 1, 3'd2, 2'd1, DEPTH - 1);

        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'h3, BASE + 32'h10, 3, 3'd2, 2'd1, 3);
        do_read(4'h5, BASE + 32'h10, 3, 3'd2, 2'd1, 0);

        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(4'h2, BASE + 32'h40, 0, 3'd2, 2'd1, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
        do_write(4'h2, BASE + 32'h40, 0, 3'd2, 2'd1, 0);
        do_read(4'h6, BASE + 32'h40, 0, 3'd2, 2'd1, 1);

        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
        for (int i = 0; i < 3; i++) ws[i] = 4'hF;
        do_write(4'h7, BASE + 32'h20, 2, 3'd2, 2'd0, 2);
        do_read(4'h8, BASE + 32'h20, 2, 3'd2, 2'd0, 0);

        do_read(4'h9, BASE + 32'(4 * DEPTH), 1, 3'd2, 2'd1, 0);
        do_read(4'hA, BASE - 32'd4, 1, 3'd2, 2'd1, 0);
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'hFEED_F00D; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'hB, BASE + 32'h30, 1, 3'd2, 2'd2, 1);
        do_read(4'hC, BASE + 32'h30, 1, 3'd2, 2'd1, 0);

        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            do_write(4'hD, BASE + 32'h80, 3, 3'd2, 2'd1, 1);
            do_read(4'hE, BASE + 32'h10, 3, 3'd2, 2'd1, 2);
        join
        do_read(4'hF, BASE + 32'h80, 3, 3'd2, 2'd1, 0);

        // Reset while beat 2 of a 4-beat read is on the bus.
        @(negedge aclk);
        arid = 4'h4; araddr = BASE; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check("rst_test_arready", arready, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_test_beat2", {rvalid, rlast}, 2'b10);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_rvalid", rvalid, 1'b0);
        check("async_rst_arready", arready, 1'b0);
        rready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("arready_after_midrst", arready, 1'b1);
        do_read(4'h4, BASE, 3, 3'd2, 2'd1, 1);

        for (int it = 0; it < 25; it++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  bu;
            int          len, lp;
            if ($urandom_range(0, 4) == 0) begin
                a   = BASE + 32'($urandom_range(0, 63));
                len = int'($urandom_range(0, 3));
                sz  = 3'($urandom_range(0, 3));
                bu  = 2'($urandom_range(0, 3));
            end else begin
                a   = BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 8));
                len = int'($urandom_range(0, 7));
                sz  = 3'($urandom_range(0, 2));
                bu  = 2'($urandom_range(0, 1));
            end
            lp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len + 2)) : len;
            for (int i = 0; i <= lp; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(4'($urandom), a, len, sz, bu, lp);
            do_read(4'($urandom), a, len, sz, bu, int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
